// File: rtl/cpu_checker.sv
// rtl/cpu_checker.sv - streaming checker for CPU register/memory write trace lines
//
// Purpose: consumes one ASCII character per clock and recognises lines of the form
//   ^<time:1-4 dec>@<pc:8 hex>: *( $<grf:1-4 dec> | *<addr:8 hex> ) *<= *<data:8 hex>#
// On the edge that samples a legal line's '#', it reports the line type and the
// semantic error bits for one cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   char[7:0]    in   ASCII character, one consumed per rising edge
//   freq[15:0]   in   clock frequency value (even, >= 2, stable during a line)
//   format_type  out  0 none/invalid, 1 register write, 2 memory write (one-cycle pulse)
//   error_code   out  bit0 time, bit1 pc, bit2 addr, bit3 grf (valid with format_type)
module cpu_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code
);

  typedef enum logic [3:0] {
    S_IDLE,  // waiting for '^'
    S_TIME,  // decimal time digits, ended by '@'
    S_PC,    // 8 hex pc digits, ended by ':'
    S_SP0,   // spaces before '$' or '*'
    S_GRF,   // decimal register digits
    S_ADDR,  // 8 hex address digits
    S_SP1,   // spaces before '<'
    S_EQ,    // '<' seen, expecting '='
    S_SP2,   // spaces before data
    S_DATA   // data hex digits, ended by '#'
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // digits accepted in the current field
  logic [13:0] time_q, time_d;      // at most 9999
  logic [13:0] grf_q, grf_d;        // at most 9999
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        is_mem_q, is_mem_d;  // line type selected by '$' or '*'
  logic [1:0]  format_type_q, format_type_d;
  logic [3:0]  error_code_q, error_code_d;

  // Character classes
  logic       is_dec;
  logic       is_hex;
  logic [3:0] nibble;
  logic [15:0] half_freq;
  logic [15:0] time_rem;
  logic        time_bad, pc_bad, addr_bad, grf_bad;

  always_comb begin
    is_dec = (char >= "0") && (char <= "9");
    // Only lowercase a-f are legal hex letters.
    is_hex = is_dec || ((char >= "a") && (char <= "f"));
    // '0'-'9' map to low nibble directly; 'a'-'f' have low nibble 1-6, so add 9.
    nibble = is_dec ? char[3:0] : (char[3:0] + 4'd9);
  end

  always_comb begin
    half_freq = freq >> 1;
    time_rem  = {2'b00, time_q} % half_freq;
    time_bad  = (time_rem != 16'd0);
    pc_bad    = !((pc_q >= 32'h0000_3000) && (pc_q <= 32'h0000_4fff) && (pc_q[1:0] == 2'b00));
    addr_bad  = !((addr_q <= 32'h0000_2fff) && (addr_q[1:0] == 2'b00));
    grf_bad   = (grf_q > 14'd31);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    time_d        = time_q;
    grf_d         = grf_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    is_mem_d      = is_mem_q;
    format_type_d = 2'd0;
    error_code_d  = 4'd0;

    if (char == "^") begin
      // A caret restarts a line from any state, including mid-line.
      state_d  = S_TIME;
      cnt_d    = 4'd0;
      time_d   = 14'd0;
      grf_d    = 14'd0;
      pc_d     = 32'd0;
      addr_d   = 32'd0;
      is_mem_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_TIME: begin
          if (is_dec && (cnt_q < 4'd4)) begin
            time_d = time_q * 14'd10 + {10'd0, char[3:0]};
            cnt_d  = cnt_q + 4'd1;
          end else if ((char == "@") && (cnt_q != 4'd0)) begin
            state_d = S_PC;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PC: begin
          if (is_hex && (cnt_q < 4'd8)) begin
            pc_d  = {pc_q[27:0], nibble};
            cnt_d = cnt_q + 4'd1;
          end else if ((char == ":") && (cnt_q == 4'd8)) begin
            state_d = S_SP0;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SP0: begin
          if (char == " ") begin
            state_d = S_SP0;
          end else if (char == "$") begin
            state_d  = S_GRF;
            cnt_d    = 4'd0;
            is_mem_d = 1'b0;
          end else if (char == "*") begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            is_mem_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GRF: begin
          if (is_dec && (cnt_q < 4'd4)) begin
            grf_d = grf_q * 14'd10 + {10'd0, char[3:0]};
            cnt_d = cnt_q + 4'd1;
          end else if ((char == " ") && (cnt_q != 4'd0)) begin
            state_d = S_SP1;
          end else if ((char == "<") && (cnt_q != 4'd0)) begin
            state_d = S_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          if (is_hex && (cnt_q < 4'd8)) begin
            addr_d = {addr_q[27:0], nibble};
            cnt_d  = cnt_q + 4'd1;
          end else if ((char == " ") && (cnt_q == 4'd8)) begin
            state_d = S_SP1;
          end else if ((char == "<") && (cnt_q == 4'd8)) begin
            state_d = S_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SP1: begin
          if (char == " ") begin
            state_d = S_SP1;
          end else if (char == "<") begin
            state_d = S_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EQ: begin
          state_d = (char == "=") ? S_SP2 : S_IDLE;
        end
        S_SP2: begin
          if (char == " ") begin
            state_d = S_SP2;
          end else if (is_hex) begin
            state_d = S_DATA;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (is_hex && (cnt_q < 4'd8)) begin
            cnt_d = cnt_q + 4'd1;
          end else if ((char == "#") && (cnt_q == 4'd8)) begin
            state_d       = S_IDLE;
            format_type_d = is_mem_q ? 2'd2 : 2'd1;
            error_code_d  = {(!is_mem_q && grf_bad), (is_mem_q && addr_bad), pc_bad, time_bad};
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      time_q        <= 14'd0;
      grf_q         <= 14'd0;
      pc_q          <= 32'd0;
      addr_q        <= 32'd0;
      is_mem_q      <= 1'b0;
      format_type_q <= 2'd0;
      error_code_q  <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      time_q        <= time_d;
      grf_q         <= grf_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      is_mem_q      <= is_mem_d;
      format_type_q <= format_type_d;
      error_code_q  <= error_code_d;
    end
  end

  assign format_type = format_type_q;
  assign error_code  = error_code_q;

endmodule

// File: tb/tb_cpu_checker.sv
// tb/tb_cpu_checker.sv - directed self-checking bench for cpu_checker
module tb_cpu_checker;

  logic        clk;
  logic        reset;
  logic [7:0]  ch;
  logic [15:0] freq;
  logic [1:0]  ft;
  logic [3:0]  ec;

  int checks;
  int errors;

  cpu_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (ch),
    .freq        (freq),
    .format_type (ft),
    .error_code  (ec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_ft(input string tag, input logic [1:0] exp_v);
    checks++;
    assert (ft === exp_v) else begin
      errors++;
      $error("FAIL %s format_type: got %0d expected %0d", tag, ft, exp_v);
    end
  endtask

  task automatic chk_ec(input string tag, input logic [3:0] exp_v);
    checks++;
    assert (ec === exp_v) else begin
      errors++;
      $error("FAIL %s error_code: got %b expected %b", tag, ec, exp_v);
    end
  endtask

  task automatic send_chars(input string s);
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      @(posedge clk);
      #1;
    end
  endtask

  // Sends a whole line, checks the pulse after the last character, then feeds
  // a '^' and checks the pulse is gone. Outputs must stay 0 before the last char.
  task automatic send_line(input string tag, input string s,
                           input logic [1:0] eft, input logic [3:0] eec);
    logic quiet;
    quiet = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      @(posedge clk);
      #1;
      if ((i < s.len() - 1) && ((ft !== 2'd0) || (ec !== 4'd0))) quiet = 1'b0;
    end
    chk_ft(tag, eft);
    chk_ec(tag, eec);
    checks++;
    assert (quiet === 1'b1) else begin
      errors++;
      $error("FAIL %s early_pulse: got %0d expected 1", tag, quiet);
    end
    ch = "^";
    @(posedge clk);
    #1;
    chk_ft({tag, "_after"}, 2'd0);
    chk_ec({tag, "_after"}, 4'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ch     = " ";
    freq   = 16'd2;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_ft("reset", 2'd0);
    chk_ec("reset", 4'd0);
    reset = 1'b0;

    freq = 16'd2;
    send_line("grf_ok",    "^1023@00003000: $31 <= 89abcdef#", 2'd1, 4'b0000);
    send_line("pc_low",    "^1023@000020fc: *00000004 <= 89abcdef#", 2'd2, 4'b0010);
    freq = 16'd8;
    send_line("mem_errs",  "^6@00003001:*00003000<=00000000#", 2'd2, 4'b0111);
    freq = 16'd2;
    send_line("grf_32",    "^1@00003000:$32<=00000000#", 2'd1, 4'b1000);
    send_line("grf_5dig",  "^1@00003000:$00031<=00000000#", 2'd0, 4'b0000);
    send_line("addr_short","^1023@000020fc:*32<= 89abcdef#", 2'd0, 4'b0000);
    send_line("restart",   "^12@000^5@00003000:$1<=0000000a#", 2'd1, 4'b0000);
    send_line("upper_hex", "^1@00003A00:$1<=00000000#", 2'd0, 4'b0000);
    send_line("bounds_ok", "^9999@00004ffc:*00002ffc<=ffffffff#", 2'd2, 4'b0000);
    send_line("time_5dig", "^12345@00003000:$1<=00000000#", 2'd0, 4'b0000);
    send_line("pc_pc_hi",  "^1@00005000:$0<=00000000#", 2'd1, 4'b0010);
    freq = 16'd4;
    send_line("pc_wide",   "^2@00013000:$0<=00000000#", 2'd1, 4'b0010);
    send_line("time_mod",  "^3@00003000:$0<=00000000#", 2'd1, 4'b0001);
    send_line("addr_3000", "^4@00003000:*00003000<=00000000#", 2'd2, 4'b0100);
    send_line("data_short","^4@00003000:$1<=0000000#", 2'd0, 4'b0000);

    // Reset in the middle of a line: the remainder must not complete it.
    freq = 16'd2;
    send_chars("^1@0000");
    reset = 1'b1;
    ch    = "3";
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_line("mid_reset", "000:$1<=00000000#", 2'd0, 4'b0000);

    // Parser still works after the reset.
    send_line("post_reset", "^2@00003004:$7<=00000000#", 2'd1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
